// File: rtl/sreg_branch_unit.sv
// AVR-style conditional/unconditional branch resolver: IDLE -> EVAL -> (REDIRECT -> FLUSH) -> IDLE.
// Optional macro SREG_BRANCH_STATS_EN adds saturating taken/not-taken counters.
module sreg_branch_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [1:0]  req_type,
   input  logic [2:0]  bit_sel,
   input  logic [11:0] offset,
   input  logic [15:0] pc_in,
   input  logic [7:0]  sreg,
   output logic        req_ready,
   output logic        pc_load,
   output logic [15:0] pc_target,
   output logic        flush,
   output logic        done,
   output logic        taken
`ifdef SREG_BRANCH_STATS_EN
   ,
   output logic [15:0] taken_count,
   output logic [15:0] not_taken_count
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_EVAL     = 2'd1,
      S_REDIRECT = 2'd2,
      S_FLUSH    = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      BR_BRBS = 2'b00,
      BR_BRBC = 2'b01,
      BR_RJMP = 2'b10,
      BR_RSVD = 2'b11
   } br_type_t;

   state_t      state;
   br_type_t    lat_type;
   logic [2:0]  lat_bit;
   logic [11:0] lat_offset;
   logic [15:0] lat_pc;

   logic        cond;
   logic [15:0] sext_offset;
   logic [15:0] branch_target;

   // Decision uses the live sreg during EVAL so a flag write in the acceptance cycle is seen.
   always_comb begin
      cond        = 1'b0;
      sext_offset = '0;
      unique case (lat_type)
         BR_BRBS: cond = sreg[lat_bit];
         BR_BRBC: cond = ~sreg[lat_bit];
         BR_RJMP: cond = 1'b1;
         default: cond = 1'b0;
      endcase
      if (lat_type == BR_RJMP)
         sext_offset = {{4{lat_offset[11]}}, lat_offset};
      else
         sext_offset = {{9{lat_offset[6]}}, lat_offset[6:0]};
      branch_target = lat_pc + 16'd1 + sext_offset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         req_ready  <= 1'b1;
         pc_load    <= 1'b0;
         flush      <= 1'b0;
         done       <= 1'b0;
         taken      <= 1'b0;
         pc_target  <= '0;
         lat_type   <= BR_BRBS;
         lat_bit    <= '0;
         lat_offset <= '0;
         lat_pc     <= '0;
`ifdef SREG_BRANCH_STATS_EN
         taken_count     <= '0;
         not_taken_count <= '0;
`endif
      end else begin
         pc_load <= 1'b0;
         flush   <= 1'b0;
         done    <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (req_valid && req_ready) begin
                  lat_type   <= br_type_t'(req_type);
                  lat_bit    <= bit_sel;
                  lat_offset <= offset;
                  lat_pc     <= pc_in;
                  req_ready  <= 1'b0;
                  state      <= S_EVAL;
               end
            end
            S_EVAL: begin
               if (cond) begin
                  taken     <= 1'b1;
                  pc_target <= branch_target;
                  state     <= S_REDIRECT;
`ifdef SREG_BRANCH_STATS_EN
                  if (taken_count != '1)
                     taken_count <= taken_count + 16'd1;
`endif
               end else begin
                  taken     <= 1'b0;
                  done      <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
`ifdef SREG_BRANCH_STATS_EN
                  if (not_taken_count != '1)
                     not_taken_count <= not_taken_count + 16'd1;
`endif
               end
            end
            S_REDIRECT: begin
               pc_load <= 1'b1;
               state   <= S_FLUSH;
            end
            S_FLUSH: begin
               flush     <= 1'b1;
               done      <= 1'b1;
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               req_ready <= 1'b1;
               state     <= S_IDLE;
            end
         endcase
      end
   end

endmodule
